multicycle_control_unit: RTL and testbench

//  Moore FSM main control for the multicycle RV32I core. Replaces the single-cycle opcode decoder.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Moore main-control FSM for the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB
// with memory handshakes, an illegal-opcode trap and a memory-wait timeout trap.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ENABLE_JUMP  = 1,
  parameter int ENABLE_UPPER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic [1:0] ALUSrcA,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_src_a;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  state_t          state, state_nxt;
  logic [6:0]      op_q, op_nxt;
  ctrl_t           ctrl_q;
  logic [CW-1:0]   cnt;
  logic            started;
  logic            timeout, waiting, trap_ill, trap_flt;

  function automatic logic op_legal(logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR: op_legal = 1'b1;
      OP_JAL, OP_JALR:                 op_legal = (ENABLE_JUMP != 0);
      OP_LUI, OP_AUIPC:                op_legal = (ENABLE_UPPER != 0);
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  // Control word for the state being entered; outputs are registered from it.
  function automatic ctrl_t ctrl_for(state_t s, logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: c.imem_req = 1'b1;
      EXEC: begin
        case (op)
          OP_R:         c.alu_op = 2'b10;
          OP_I:         begin c.alu_src = 1'b1; c.alu_op = 2'b11; end
          OP_LW, OP_SW: c.alu_src = 1'b1;
          OP_BR:        begin c.alu_op = 2'b01; c.branch = 1'b1; end
          OP_JAL:       begin c.alu_src_a = 2'b01; c.alu_src = 1'b1; end
          OP_JALR:      c.alu_src = 1'b1;
          OP_LUI:       begin c.alu_src_a = 2'b10; c.alu_src = 1'b1; end
          OP_AUIPC:     begin c.alu_src_a = 2'b01; c.alu_src = 1'b1; end
          default:      ;
        endcase
      end
      MEM: begin
        c.dmem_req  = 1'b1;
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
      end
      WB: begin
        c.reg_write = 1'b1;
        if (op == OP_LW) c.mem_to_reg = 2'b01;
        if (op == OP_JAL || op == OP_JALR) begin
          c.mem_to_reg = 2'b10;
          c.jump       = 1'b1;
          c.pc_write   = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    trap_ill  = 1'b0;
    trap_flt  = 1'b0;
    timeout   = (MEM_TIMEOUT != 0) && (cnt == LIMIT);
    waiting   = 1'b0;
    if (!started) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          waiting = !imem_ack;
          if (imem_ack)     state_nxt = DECODE;
          else if (timeout) begin state_nxt = TRAP; trap_flt = 1'b1; end
        end
        DECODE: begin
          op_nxt = opcode;
          if (op_legal(opcode)) state_nxt = EXEC;
          else begin state_nxt = TRAP; trap_ill = 1'b1; end
        end
        EXEC: begin
          if (op_q == OP_LW || op_q == OP_SW) state_nxt = MEM;
          else if (op_q == OP_BR)             state_nxt = FETCH;
          else                                state_nxt = WB;
        end
        MEM: begin
          waiting = !dmem_ack;
          if (dmem_ack)     state_nxt = (op_q == OP_LW) ? WB : FETCH;
          else if (timeout) begin state_nxt = TRAP; trap_flt = 1'b1; end
        end
        WB:      state_nxt = FETCH;
        default: state_nxt = TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      op_q    <= '0;
      ctrl_q  <= '0;
      cnt     <= '0;
      started <= 1'b0;
      illegal <= 1'b0;
      fault   <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nxt;
      op_q    <= op_nxt;
      ctrl_q  <= ctrl_for(state_nxt, op_nxt);
      cnt     <= (waiting && state_nxt == state) ? cnt + CW'(1) : '0;
      illegal <= illegal | trap_ill;
      fault   <= fault | trap_flt;
    end
  end

  // IR load and PC+4 happen in the cycle the instruction word arrives.
  assign ir_write = ctrl_q.imem_req & imem_ack;
  assign pc_write = ctrl_q.pc_write | (ctrl_q.imem_req & imem_ack);
  assign imem_req = ctrl_q.imem_req;
  assign dmem_req = ctrl_q.dmem_req;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign branch   = ctrl_q.branch;
  assign jump     = ctrl_q.jump;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ALUSrc   = ctrl_q.alu_src;
  assign ALUOp    = ctrl_q.alu_op;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: random instruction stream against a per-instruction cycle
// model, plus trap, timeout and reset scenarios on a second, restricted instance.
module tb_multicycle_control_unit;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

  typedef struct packed {
    logic [2:0] st;
    logic ireq, dreq, mrd, mwr, irw, pcw, br, jmp;
    logic [1:0] asa;
    logic asb;
    logic [1:0] aop, m2r;
    logic rw, ill, flt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, imem_ack_a, dmem_ack_a;
  logic [6:0] opcode_a;
  logic imem_req_a, dmem_req_a, MemRead_a, MemWrite_a, ir_write_a, pc_write_a, branch_a, jump_a;
  logic ALUSrc_a, RegWrite_a, illegal_a, fault_a;
  logic [1:0] ALUSrcA_a, ALUOp_a, MemtoReg_a;
  logic [2:0] state_o_a;

  logic rst_b, imem_ack_b, dmem_ack_b;
  logic [6:0] opcode_b;
  logic imem_req_b, dmem_req_b, MemRead_b, MemWrite_b, ir_write_b, pc_write_b, branch_b, jump_b;
  logic ALUSrc_b, RegWrite_b, illegal_b, fault_b;
  logic [1:0] ALUSrcA_b, ALUOp_b, MemtoReg_b;
  logic [2:0] state_o_b;

  multicycle_control_unit dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode_a), .imem_ack(imem_ack_a), .dmem_ack(dmem_ack_a),
    .imem_req(imem_req_a), .dmem_req(dmem_req_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a),
    .ir_write(ir_write_a), .pc_write(pc_write_a), .branch(branch_a), .jump(jump_a),
    .ALUSrcA(ALUSrcA_a), .ALUSrc(ALUSrc_a), .ALUOp(ALUOp_a), .MemtoReg(MemtoReg_a),
    .RegWrite(RegWrite_a), .illegal(illegal_a), .fault(fault_a), .state_o(state_o_a)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4), .ENABLE_JUMP(0), .ENABLE_UPPER(0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b), .imem_ack(imem_ack_b), .dmem_ack(dmem_ack_b),
    .imem_req(imem_req_b), .dmem_req(dmem_req_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .branch(branch_b), .jump(jump_b),
    .ALUSrcA(ALUSrcA_b), .ALUSrc(ALUSrc_b), .ALUOp(ALUOp_b), .MemtoReg(MemtoReg_b),
    .RegWrite(RegWrite_b), .illegal(illegal_b), .fault(fault_b), .state_o(state_o_b)
  );

  int checks = 0;
  int failures = 0;
  obs_t e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t obs_a();
    obs_t o;
    o = {state_o_a, imem_req_a, dmem_req_a, MemRead_a, MemWrite_a, ir_write_a, pc_write_a,
         branch_a, jump_a, ALUSrcA_a, ALUSrc_a, ALUOp_a, MemtoReg_a, RegWrite_a, illegal_a, fault_a};
    return o;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  // Datapath controls during the execute step, straight from the opcode table.
  function automatic obs_t exec_exp(input logic [6:0] op);
    obs_t o;
    o = base(3'd2);
    case (op)
      R:       o.aop = 2'b10;
      I:       begin o.asb = 1'b1; o.aop = 2'b11; end
      LW, SW:  o.asb = 1'b1;
      BR:      begin o.aop = 2'b01; o.br = 1'b1; end
      JAL:     begin o.asa = 2'b01; o.asb = 1'b1; end
      JALR:    o.asb = 1'b1;
      LUI:     begin o.asa = 2'b10; o.asb = 1'b1; end
      AUIPC:   begin o.asa = 2'b01; o.asb = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic cycle_a(input string tag, input logic ia, input logic da);
    @(negedge clk);
    imem_ack_a = ia;
    dmem_ack_a = da;
    #1;
    check(tag, 32'(obs_a()), 32'(e));
  endtask

  task automatic release_a();
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  // Walks one instruction through the cycles the rules prescribe; returns 1 if it trapped.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw, output logic trapped);
    bit legal;
    legal = (op == R || op == I || op == LW || op == SW || op == BR || op == JAL ||
             op == JALR || op == LUI || op == AUIPC);
    trapped = 1'b0;
    opcode_a = op;
    for (int k = 0; k <= iw; k++) begin
      e = base(3'd0);
      e.ireq = 1'b1;
      e.irw = (k == iw);
      e.pcw = (k == iw);
      cycle_a("fetch", k == iw, 1'($urandom_range(0, 1)));
    end
    e = base(3'd1);
    cycle_a("decode", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if (!legal) begin
      trapped = 1'b1;
      return;
    end
    e = exec_exp(op);
    cycle_a("exec", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if (op == BR) return;
    if (op == LW || op == SW) begin
      for (int k = 0; k <= dw; k++) begin
        e = base(3'd3);
        e.dreq = 1'b1;
        e.mrd = (op == LW);
        e.mwr = (op == SW);
        cycle_a("mem", 1'($urandom_range(0, 1)), k == dw);
      end
      if (op == SW) return;
    end
    e = base(3'd4);
    e.rw = 1'b1;
    if (op == LW) e.m2r = 2'b01;
    if (op == JAL || op == JALR) begin
      e.m2r = 2'b10;
      e.jmp = 1'b1;
      e.pcw = 1'b1;
    end
    cycle_a("wb", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic cycle_b(input logic ia);
    @(negedge clk);
    imem_ack_b = ia;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [9];
    logic trapped;
    ops = '{R, I, LW, SW, BR, JAL, JALR, LUI, AUIPC};
    rst_a = 1'b0; rst_b = 1'b0;
    imem_ack_a = 1'b0; dmem_ack_a = 1'b0; opcode_a = R;
    imem_ack_b = 1'b0; dmem_ack_b = 1'b0; opcode_b = R;

    e = '0;
    for (int k = 0; k < 3; k++) cycle_a("reset_state", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    release_a();

    run_instr(R, 0, 0, trapped);
    run_instr(LW, 0, 3, trapped);
    run_instr(JAL, 1, 0, trapped);
    run_instr(SW, 16, 16, trapped);
    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), trapped);
    check("legal_no_trap", 32'(trapped), 32'd0);

    run_instr(7'b1111111, 0, 0, trapped);
    check("illegal_trapped", 32'(trapped), 32'd1);
    e = base(3'd5);
    e.ill = 1'b1;
    for (int k = 0; k < 20; k++) cycle_a("trap_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    rst_a = 1'b0;
    e = '0;
    cycle_a("trap_reset", 1'b0, 1'b0);
    release_a();

    // Reset arriving while a store waits on memory.
    opcode_a = SW;
    e = base(3'd0); e.ireq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    cycle_a("fetch", 1'b1, 1'b0);
    e = base(3'd1);
    cycle_a("decode", 1'b0, 1'b0);
    e = exec_exp(SW);
    cycle_a("exec", 1'b0, 1'b0);
    e = base(3'd3); e.dreq = 1'b1; e.mwr = 1'b1;
    cycle_a("mem_wait", 1'b0, 1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    check("rst_drop_dreq", 32'(dmem_req_a), 32'd0);
    check("rst_drop_state", 32'(state_o_a), 32'd0);
    release_a();
    e = base(3'd0); e.ireq = 1'b1;
    cycle_a("post_rst_fetch", 1'b0, 1'b0);
    run_instr(R, 0, 0, trapped);

    // Restricted instance: timeout of 4 and disabled jump/upper opcodes.
    #1;
    check("b_reset", {29'd0, state_o_b} | {31'd0, imem_req_b}, 32'd0);
    @(negedge clk); rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle_b(1'b0);
      check("b_tmo_fetch", {state_o_b, imem_req_b, fault_b}, {3'd0, 1'b1, 1'b0});
    end
    cycle_b(1'b0);
    check("b_tmo_trap", {state_o_b, imem_req_b, fault_b, illegal_b}, {3'd5, 1'b0, 1'b1, 1'b0});
    cycle_b(1'b1);
    check("b_trap_held", {state_o_b, imem_req_b, ir_write_b, fault_b}, {3'd5, 1'b0, 1'b0, 1'b1});

    @(negedge clk); rst_b = 1'b0;
    #1;
    check("b_fault_clear", {fault_b, illegal_b}, 2'b00);
    @(negedge clk); rst_b = 1'b1;
    opcode_b = JAL;
    for (int k = 0; k < 4; k++) cycle_b(1'b0);
    cycle_b(1'b1);
    check("b_late_ack", {state_o_b, ir_write_b, pc_write_b}, {3'd0, 1'b1, 1'b1});
    cycle_b(1'b0);
    check("b_decode", 32'(state_o_b), 32'd1);
    cycle_b(1'b0);
    check("b_jal_trap", {state_o_b, illegal_b, fault_b}, {3'd5, 1'b1, 1'b0});

    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    opcode_b = LUI;
    cycle_b(1'b1);
    cycle_b(1'b0);
    cycle_b(1'b0);
    check("b_lui_trap", {state_o_b, illegal_b}, {3'd5, 1'b1});

    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    opcode_b = LW;
    cycle_b(1'b1);
    cycle_b(1'b0);
    cycle_b(1'b0);
    check("b_lw_exec", {state_o_b, ALUSrc_b, ALUOp_b}, {3'd2, 1'b1, 2'b00});
    for (int k = 0; k < 5; k++) cycle_b(1'b0);
    check("b_mem_wait", {state_o_b, dmem_req_b, MemRead_b}, {3'd3, 1'b1, 1'b1});
    cycle_b(1'b0);
    check("b_mem_tmo", {state_o_b, fault_b, dmem_req_b}, {3'd5, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
